// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexes one shared hex->7-segment decoder across NDIG digits and
// commits all decoded digits to the active-low HEX outputs in a single cycle.
module seg7_scan_ctrl #(
    parameter int unsigned NDIG      = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iLOAD,
    input  logic [4*NDIG-1:0]   iVALUE,
    input  logic                iLZB,
    input  logic [NDIG-1:0]     iBLINK_MASK,
    output logic                oREADY,
    output logic                oDONE,
    output logic [3:0]          oLUT_DIG,
    input  logic [6:0]          iLUT_SEG,
    output logic [7*NDIG-1:0]   oHEX
);

    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CNTW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic                     seen_nz_q, seen_nz_d;
    logic [NDIG-1:0][3:0]     value_q, value_d;
    logic                     lzb_q, lzb_d;
    logic [NDIG-1:0]          mask_ld_q, mask_ld_d;
    logic [NDIG-1:0]          mask_q, mask_d;
    logic [NDIG-1:0][6:0]     shadow_q, shadow_d;
    logic [NDIG-1:0][6:0]     disp_q, disp_d;
    logic                     done_q, done_d;
    logic [CNTW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                     phase_q, phase_d;
    logic [3:0]               nibble;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            seen_nz_q   <= 1'b0;
            value_q     <= '0;
            lzb_q       <= 1'b0;
            mask_ld_q   <= '0;
            mask_q      <= '0;
            shadow_q    <= '1;
            disp_q      <= '1;
            done_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seen_nz_q   <= seen_nz_d;
            value_q     <= value_d;
            lzb_q       <= lzb_d;
            mask_ld_q   <= mask_ld_d;
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            done_q      <= done_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign nibble = value_q[idx_q];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seen_nz_d = seen_nz_q;
        value_d   = value_q;
        lzb_d     = lzb_q;
        mask_ld_d = mask_ld_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        oLUT_DIG  = 4'h0;

        unique case (state_q)
            IDLE: begin
                if (iLOAD) begin
                    value_d   = iVALUE;
                    lzb_d     = iLZB;
                    mask_ld_d = iBLINK_MASK;
                    idx_d     = IDXW'(NDIG - 1);
                    seen_nz_d = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                oLUT_DIG = nibble;
                // Scanning MSD first lets seen_nz mark every digit left of the first non-zero.
                if (lzb_q && (nibble == 4'h0) && !seen_nz_q && (idx_q != '0)) begin
                    shadow_d[idx_q] = 7'h7F;
                end else begin
                    shadow_d[idx_q] = iLUT_SEG;
                end
                seen_nz_d = seen_nz_q | (nibble != 4'h0);
                if (idx_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            COMMIT: begin
                disp_d  = shadow_q;
                mask_d  = mask_ld_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + CNTW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == CNTW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NDIG; k++) begin
            oHEX[7*k +: 7] = disp_q[k] | {7{phase_q & mask_q[k]}};
        end
    end

    assign oREADY = (state_q == IDLE) && !iRST;
    assign oDONE  = done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: transaction-level display model plus literal
// checks for latency, blanking, blink cadence, back-to-back loads and reset abort.
module tb_seg7_scan_ctrl;

    localparam int NDIG = 6;
    localparam int BD   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [23:0] value = '0;
    logic [5:0]  mask = '0;
    logic        ready, done;
    logic [3:0]  lut_dig;
    logic [6:0]  lut_seg;
    logic [41:0] hex;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40; 4'h1: seg_of = 7'h79; 4'h2: seg_of = 7'h24; 4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19; 4'h5: seg_of = 7'h12; 4'h6: seg_of = 7'h02; 4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00; 4'h9: seg_of = 7'h10; 4'hA: seg_of = 7'h08; 4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46; 4'hD: seg_of = 7'h21; 4'hE: seg_of = 7'h06; default: seg_of = 7'h0E;
        endcase
    endfunction

    assign lut_seg = seg_of(lut_dig);

    seg7_scan_ctrl #(.NDIG(NDIG), .BLINK_DIV(BD)) dut (
        .iCLK(clk), .iRST(rst), .iLOAD(load), .iVALUE(value), .iLZB(lzb),
        .iBLINK_MASK(mask), .oREADY(ready), .oDONE(done), .oLUT_DIG(lut_dig),
        .iLUT_SEG(lut_seg), .oHEX(hex)
    );

    // Model: busy counts edges until commit; display computed directly from the value.
    int          m_busy = 0;
    logic [23:0] m_val = '0;
    logic [5:0]  m_mask_pend = '0;
    logic [5:0]  m_mask = '0;
    logic [6:0]  m_disp [NDIG];
    logic [6:0]  m_new  [NDIG];
    logic        m_done = 1'b0;
    int unsigned m_ecount = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_done = 1'b0; m_mask = '0; m_mask_pend = '0; m_ecount = 0;
            for (int k = 0; k < NDIG; k++) m_disp[k] = 7'h7F;
        end else begin
            m_done = 1'b0;
            m_ecount++;
            if (m_busy == 0) begin
                if (load) begin
                    m_busy = NDIG + 1;
                    m_val = value;
                    m_mask_pend = mask;
                    for (int k = 0; k < NDIG; k++)
                        m_new[k] = (lzb && k != 0 && (value >> (4*k)) == 24'h0) ? 7'h7F : seg_of(value[4*k +: 4]);
                end
            end else if (m_busy == 1) begin
                for (int k = 0; k < NDIG; k++) m_disp[k] = m_new[k];
                m_mask = m_mask_pend;
                m_done = 1'b1;
                m_busy = 0;
            end else begin
                m_busy--;
            end
        end
    endtask

    task automatic step();
        logic [41:0] eh;
        logic [3:0]  el;
        bit          phase;
        @(posedge clk);
        model_edge();
        #1;
        phase = ((m_ecount / BD) % 2) == 1;
        for (int k = 0; k < NDIG; k++)
            eh[7*k +: 7] = m_disp[k] | ((phase && m_mask[k]) ? 7'h7F : 7'h00);
        el = (m_busy >= 2) ? m_val[4*(m_busy-2) +: 4] : 4'h0;
        check("oHEX", hex, eh);
        check("oDONE", done, m_done);
        check("oREADY", ready, (m_busy == 0) && !rst);
        check("oLUT_DIG", lut_dig, el);
        cyc++;
    endtask

    task automatic do_load(input logic [23:0] v, input logic l, input logic [5:0] m);
        int lat;
        value = v; lzb = l; mask = m; load = 1'b1;
        step();
        load = 1'b0;
        lat = 0;
        while (lat < 20) begin
            step();
            lat++;
            if (done) break;
        end
        check("load_to_done_latency", lat, NDIG + 1);
    endtask

    function automatic logic [23:0] rand_value();
        logic [23:0] v;
        for (int k = 0; k < NDIG; k++)
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int   d_cyc[$];
        int   changes, others;
        logic [41:0] prev;

        // Reset
        rst = 1'b1;
        step(); step();
        check("reset_hex_all_off", hex, 42'h3FF_FFFF_FFFF);
        check("ready_low_in_reset", ready, 1'b0);
        rst = 1'b0;
        step();
        check("ready_after_reset", ready, 1'b1);

        // Plain decode, LSD first in the literal below is rightmost
        do_load(24'h12AB0F, 1'b0, 6'b0);
        check("hex_12AB0F", hex, {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E});
        step();
        check("done_one_cycle", done, 1'b0);

        // Leading-zero blanking
        do_load(24'h00000A, 1'b1, 6'b0);
        check("lzb_00000A", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08});
        do_load(24'h000000, 1'b1, 6'b0);
        check("lzb_zero", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        do_load(24'h000100, 1'b1, 6'b0);
        check("lzb_internal_zeros", hex, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});

        // Blink on digit 0 only
        do_load(24'h123456, 1'b0, 6'b000001);
        prev = hex; changes = 0; others = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (hex[6:0] != prev[6:0]) changes++;
            if (hex[41:7] != prev[41:7]) others++;
            prev = hex;
        end
        check("blink_toggles_in_16", changes, 4);
        check("blink_other_digits_static", others, 0);

        // Continuous load with value churn mid-scan
        load = 1'b1; mask = '0;
        for (int i = 0; i < 30; i++) begin
            value = 24'($urandom); lzb = 1'($urandom);
            step();
            if (done) d_cyc.push_back(cyc);
        end
        load = 1'b0;
        check("held_load_done_count", d_cyc.size() >= 3, 1'b1);
        if (d_cyc.size() >= 3) check("held_load_period", d_cyc[2] - d_cyc[1], NDIG + 2);
        for (int i = 0; i < 20 && !ready; i++) step();
        check("idle_after_held_load", ready, 1'b1);

        // Reset during the third scan cycle
        value = 24'h654321; lzb = 1'b0; mask = '0; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("abort_hex_all_off", hex, 42'h3FF_FFFF_FFFF);
        rst = 1'b0;
        step();
        check("ready_after_abort", ready, 1'b1);
        for (int i = 0; i < 10; i++) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 2) == 0);
            value = rand_value();
            lzb   = 1'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
